// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the DOF stage of the 4-stage RISC pipeline.
//   - fixed datapath widths
//   - opcode constants
//   - FS (function select), BS (branch select) and MD (mux D) encodings
//   - packed control word ctrl_t and the opcode decoder
//   - register-usage helpers used by the hazard detector
package risc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 7;

  localparam logic [OP_W-1:0] OP_NOP = 7'b0000000;
  localparam logic [OP_W-1:0] OP_ADD = 7'b0000010;
  localparam logic [OP_W-1:0] OP_SUB = 7'b0000101;
  localparam logic [OP_W-1:0] OP_AND = 7'b0001000;
  localparam logic [OP_W-1:0] OP_OR  = 7'b0001010;
  localparam logic [OP_W-1:0] OP_XOR = 7'b0001100;
  localparam logic [OP_W-1:0] OP_SLT = 7'b1100101;
  localparam logic [OP_W-1:0] OP_ADI = 7'b0100010;
  localparam logic [OP_W-1:0] OP_SBI = 7'b0100101;
  localparam logic [OP_W-1:0] OP_ANI = 7'b0101000;
  localparam logic [OP_W-1:0] OP_ORI = 7'b0101010;
  localparam logic [OP_W-1:0] OP_XRI = 7'b0101100;
  localparam logic [OP_W-1:0] OP_AIU = 7'b1100010;
  localparam logic [OP_W-1:0] OP_SIU = 7'b1000101;
  localparam logic [OP_W-1:0] OP_NOT = 7'b0101110;
  localparam logic [OP_W-1:0] OP_MOV = 7'b1000000;
  localparam logic [OP_W-1:0] OP_LSL = 7'b0110000;
  localparam logic [OP_W-1:0] OP_LSR = 7'b0110001;
  localparam logic [OP_W-1:0] OP_LD  = 7'b0100001;
  localparam logic [OP_W-1:0] OP_ST  = 7'b0000001;
  localparam logic [OP_W-1:0] OP_JMR = 7'b1100001;
  localparam logic [OP_W-1:0] OP_BZ  = 7'b0100000;
  localparam logic [OP_W-1:0] OP_BNZ = 7'b1100000;
  localparam logic [OP_W-1:0] OP_JMP = 7'b1000100;
  localparam logic [OP_W-1:0] OP_JML = 7'b0000111;

  localparam logic [4:0] FS_PASSA = 5'd0;
  localparam logic [4:0] FS_ADD   = 5'd2;
  localparam logic [4:0] FS_SUB   = 5'd5;
  localparam logic [4:0] FS_AND   = 5'd8;
  localparam logic [4:0] FS_OR    = 5'd10;
  localparam logic [4:0] FS_XOR   = 5'd12;
  localparam logic [4:0] FS_NOT   = 5'd14;
  localparam logic [4:0] FS_LSL   = 5'd16;
  localparam logic [4:0] FS_LSR   = 5'd17;

  localparam logic [1:0] BS_INC  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JMR  = 2'b10;
  localparam logic [1:0] BS_JUMP = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_SLT = 2'b10;

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       ma;
    logic       mb;
    logic       cs;
  } ctrl_t;

  // Undefined opcodes fall through to the all-zero word, identical to NOP.
  function automatic ctrl_t decode(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD: begin c.rw = 1'b1; c.fs = FS_ADD; end
      OP_SUB: begin c.rw = 1'b1; c.fs = FS_SUB; end
      OP_AND: begin c.rw = 1'b1; c.fs = FS_AND; end
      OP_OR:  begin c.rw = 1'b1; c.fs = FS_OR;  end
      OP_XOR: begin c.rw = 1'b1; c.fs = FS_XOR; end
      OP_SLT: begin c.rw = 1'b1; c.fs = FS_SUB; c.md = MD_SLT; end
      OP_ADI: begin c.rw = 1'b1; c.fs = FS_ADD; c.mb = 1'b1; c.cs = 1'b1; end
      OP_SBI: begin c.rw = 1'b1; c.fs = FS_SUB; c.mb = 1'b1; c.cs = 1'b1; end
      OP_ANI: begin c.rw = 1'b1; c.fs = FS_AND; c.mb = 1'b1; end
      OP_ORI: begin c.rw = 1'b1; c.fs = FS_OR;  c.mb = 1'b1; end
      OP_XRI: begin c.rw = 1'b1; c.fs = FS_XOR; c.mb = 1'b1; end
      OP_AIU: begin c.rw = 1'b1; c.fs = FS_ADD; c.mb = 1'b1; end
      OP_SIU: begin c.rw = 1'b1; c.fs = FS_SUB; c.mb = 1'b1; end
      OP_NOT: begin c.rw = 1'b1; c.fs = FS_NOT; end
      OP_MOV: begin c.rw = 1'b1; c.fs = FS_PASSA; end
      OP_LSL: begin c.rw = 1'b1; c.fs = FS_LSL; end
      OP_LSR: begin c.rw = 1'b1; c.fs = FS_LSR; end
      OP_LD:  begin c.rw = 1'b1; c.md = MD_MEM; c.fs = FS_PASSA; end
      OP_ST:  begin c.mw = 1'b1; end
      OP_JMR: begin c.bs = BS_JMR; end
      OP_BZ:  begin c.bs = BS_COND; c.ps = 1'b0; end
      OP_BNZ: begin c.bs = BS_COND; c.ps = 1'b1; end
      OP_JMP: begin c.bs = BS_JUMP; end
      OP_JML: begin c.bs = BS_JUMP; c.rw = 1'b1; c.ma = 1'b1; c.fs = FS_PASSA; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Every defined opcode other than NOP decodes to a nonzero word, so an
  // all-zero word identifies NOP and undefined opcodes alike.
  function automatic logic sa_used(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = decode(op);
    return !(c.ma || (op == OP_JMP) || (c == '0));
  endfunction

  function automatic logic sb_used(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ST: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/risc_dof_regfile.sv
// risc_dof_regfile: 32 x 32-bit register file, two combinational read ports,
// one write port. R0 reads as zero and ignores writes. A write in flight is
// forwarded to a read of the same (nonzero) register in the same cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high clear of all registers
//   rw, wa, wd        : write enable, write address, write data
//   a_addr / a_data   : read port A
//   b_addr / b_data   : read port B
module risc_dof_regfile
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rw,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_AW-1:0] b_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rw && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    a_data = regs[a_addr];
    if (a_addr == '0)                 a_data = '0;
    else if (rw && (wa == a_addr))    a_data = wd;
  end

  always_comb begin
    b_data = regs[b_addr];
    if (b_addr == '0)                 b_data = '0;
    else if (rw && (wa == b_addr))    b_data = wd;
  end

endmodule

// File: rtl/risc_dof.sv
// risc_dof: decode-and-operand-fetch stage (IF -> DOF -> EX -> WB).
// Decodes IF_DOF_IR, reads operands from the register file (with write-back
// bypass), forms the branch target NPC + sext(IM) and registers the result
// into the DOF/EX pipeline register (1-cycle latency).
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   IF_DOF_PC/NPC/IR              : IF/DOF pipeline register
//   WB_RW, WB_DA, WB_BUS_D        : register-file write-back port
//   DOF_STALL                     : IF must hold its outputs this cycle
//   DOF_EX_*                      : DOF/EX pipeline register
// Build option:
//   RISC_DOF_HAZARD_STALL_EN      : enables the RUN/STALL hazard FSM; without
//                                   it DOF_STALL is 0 and software spaces
//                                   dependent instructions with NOPs.
module risc_dof
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] IF_DOF_PC,
  input  logic [DATA_W-1:0] IF_DOF_NPC,
  input  logic [DATA_W-1:0] IF_DOF_IR,
  input  logic              WB_RW,
  input  logic [REG_AW-1:0] WB_DA,
  input  logic [DATA_W-1:0] WB_BUS_D,
  output logic              DOF_STALL,
  output logic [DATA_W-1:0] DOF_EX_PC,
  output logic              DOF_EX_RW,
  output logic              DOF_EX_MW,
  output logic              DOF_EX_PS,
  output logic [1:0]        DOF_EX_MD,
  output logic [1:0]        DOF_EX_BS,
  output logic [4:0]        DOF_EX_FS,
  output logic [REG_AW-1:0] DOF_EX_DA,
  output logic [4:0]        DOF_EX_SH,
  output logic [DATA_W-1:0] DOF_EX_BUS_A,
  output logic [DATA_W-1:0] DOF_EX_BUS_B,
  output logic [DATA_W-1:0] DOF_EX_BrA
);

  // ---- p0: decode and operand fetch ----
  logic [OP_W-1:0]   op_p0;
  logic [REG_AW-1:0] da_p0, sa_p0, sb_p0;
  logic [14:0]       im_p0;
  logic [4:0]        sh_p0;
  ctrl_t             ctrl_p0;
  logic [DATA_W-1:0] rd_a_p0, rd_b_p0;
  logic signed [DATA_W-1:0] im_sext_p0;
  logic [DATA_W-1:0] im_zext_p0;
  logic [DATA_W-1:0] bus_a_p0, bus_b_p0, bra_p0;
  logic              bubble_p0;

  assign op_p0   = IF_DOF_IR[31:25];
  assign da_p0   = IF_DOF_IR[24:20];
  assign sa_p0   = IF_DOF_IR[19:15];
  assign sb_p0   = IF_DOF_IR[14:10];
  assign im_p0   = IF_DOF_IR[14:0];
  assign sh_p0   = IF_DOF_IR[4:0];
  assign ctrl_p0 = decode(op_p0);

  risc_dof_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .rw     (WB_RW),
    .wa     (WB_DA),
    .wd     (WB_BUS_D),
    .a_addr (sa_p0),
    .b_addr (sb_p0),
    .a_data (rd_a_p0),
    .b_data (rd_b_p0)
  );

  assign im_sext_p0 = {{(DATA_W-15){im_p0[14]}}, im_p0};
  assign im_zext_p0 = {{(DATA_W-15){1'b0}}, im_p0};
  assign bus_a_p0   = ctrl_p0.ma ? IF_DOF_NPC : rd_a_p0;
  assign bus_b_p0   = !ctrl_p0.mb ? rd_b_p0 :
                      (ctrl_p0.cs ? im_sext_p0 : im_zext_p0);
  assign bra_p0     = IF_DOF_NPC + im_sext_p0;

  logic              rw_p1, mw_p1, ps_p1;
  logic [1:0]        md_p1, bs_p1;
  logic [4:0]        fs_p1, sh_p1;
  logic [REG_AW-1:0] da_p1;
  logic [DATA_W-1:0] pc_p1, bus_a_p1, bus_b_p1, bra_p1;

`ifdef RISC_DOF_HAZARD_STALL_EN
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0] state;
  logic       hazard_p0;

  // Only checked in RUN: after one bubble the producer has reached WB and
  // the bypass covers it, so the held instruction always issues from STALL.
  always_comb begin
    hazard_p0 = 1'b0;
    if ((state == ST_RUN) && rw_p1 && (da_p1 != '0))
      hazard_p0 = (sa_used(op_p0) && (da_p1 == sa_p0)) ||
                  (sb_used(op_p0) && (da_p1 == sb_p0));
  end

  always_ff @(posedge clk) begin
    if (reset)                                state <= ST_RUN;
    else if ((state == ST_RUN) && hazard_p0)  state <= ST_STALL;
    else                                      state <= ST_RUN;
  end

  assign DOF_STALL = hazard_p0;
  assign bubble_p0 = hazard_p0;
`else
  assign DOF_STALL = 1'b0;
  assign bubble_p0 = 1'b0;
`endif

  // ---- p1: DOF/EX pipeline register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_p1    <= 1'b0;
      mw_p1    <= 1'b0;
      ps_p1    <= 1'b0;
      md_p1    <= '0;
      bs_p1    <= '0;
      fs_p1    <= '0;
      sh_p1    <= '0;
      da_p1    <= '0;
      pc_p1    <= '0;
      bus_a_p1 <= '0;
      bus_b_p1 <= '0;
      bra_p1   <= '0;
    end else begin
      rw_p1    <= bubble_p0 ? 1'b0 : ctrl_p0.rw;
      mw_p1    <= bubble_p0 ? 1'b0 : ctrl_p0.mw;
      ps_p1    <= bubble_p0 ? 1'b0 : ctrl_p0.ps;
      md_p1    <= bubble_p0 ? 2'b00 : ctrl_p0.md;
      bs_p1    <= bubble_p0 ? 2'b00 : ctrl_p0.bs;
      fs_p1    <= bubble_p0 ? 5'd0 : ctrl_p0.fs;
      sh_p1    <= sh_p0;
      da_p1    <= da_p0;
      pc_p1    <= IF_DOF_PC;
      bus_a_p1 <= bus_a_p0;
      bus_b_p1 <= bus_b_p0;
      bra_p1   <= bra_p0;
    end
  end

  assign DOF_EX_PC    = pc_p1;
  assign DOF_EX_RW    = rw_p1;
  assign DOF_EX_MW    = mw_p1;
  assign DOF_EX_PS    = ps_p1;
  assign DOF_EX_MD    = md_p1;
  assign DOF_EX_BS    = bs_p1;
  assign DOF_EX_FS    = fs_p1;
  assign DOF_EX_DA    = da_p1;
  assign DOF_EX_SH    = sh_p1;
  assign DOF_EX_BUS_A = bus_a_p1;
  assign DOF_EX_BUS_B = bus_b_p1;
  assign DOF_EX_BrA   = bra_p1;

endmodule

// File: doc/risc_dof.md
# risc_dof

Decode-and-operand-fetch stage of the 4-stage RISC pipeline (IF → DOF → EX → WB). Sits directly downstream of the IF stage. Consumes `IF_DOF_PC`, `IF_DOF_NPC` and `IF_DOF_IR`, and owns the 32×32 register file and its write-back port. Decodes the opcode into a control word, fetches operands, computes the branch target, and registers everything into the DOF/EX pipeline register.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register addresses, 7-bit opcode.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `IF_DOF_PC`, `IF_DOF_NPC`, `IF_DOF_IR` in 32 each: IF pipeline register. `NPC` equals the instruction address + 1.
- `WB_RW` in 1, `WB_DA` in 5, `WB_BUS_D` in 32: register-file write port, driven from the EX/WB stage.
- `DOF_STALL` out 1: when high, IF must hold its outputs this cycle.
- `DOF_EX_PC` out 32: instruction address.
- `DOF_EX_RW`, `DOF_EX_MW`, `DOF_EX_PS` out 1 each.
- `DOF_EX_MD`, `DOF_EX_BS` out 2 each.
- `DOF_EX_FS` out 5.
- `DOF_EX_DA`, `DOF_EX_SH` out 5 each.
- `DOF_EX_BUS_A`, `DOF_EX_BUS_B`, `DOF_EX_BrA` out 32 each.

## Operation
- **Field split:** opcode `IR[31:25]`, DA `IR[24:20]`, SA `IR[19:15]`, SB `IR[14:10]`, IM `IR[14:0]`, SH `IR[4:0]`.
- **Register file:**
  - R0 always reads 0; writes to R0 are ignored.
  - Write occurs on the clock edge when `WB_RW=1`.
  - Reads are combinational with write bypass: when `WB_RW=1` and `WB_DA` equals the read address (nonzero), the read returns `WB_BUS_D`.
- **Bus A:** `IF_DOF_NPC` when MA=1, else R[SA].
- **Bus B:** R[SB] when MB=0. When MB=1, IM sign-extended if CS=1, zero-extended if CS=0.
- **Branch target:** `BrA = IF_DOF_NPC + sign-extended IM`, 32-bit wrap-around.
- **BS encoding** (matches the IF next-PC mux): 00 = PC+1; 01 = conditional, where BZ uses PS=0 and BNZ uses PS=1; 10 = jump to register (JMR); 11 = unconditional branch (JMP, JML).
- **Decode** (fields not listed are 0):
  - NOP `0000000`.
  - ADD `0000010`, SUB `0000101`, AND `0001000`, OR `0001010`, XOR `0001100`: RW=1, FS=op.
  - SLT `1100101`: RW=1, FS=SUB, MD=10.
  - ADI `0100010`, SBI `0100101`: RW=1, MB=1, CS=1.
  - ANI `0101000`, ORI `0101010`, XRI `0101100`, AIU `1100010`, SIU `1000101`: RW=1, MB=1, CS=0.
  - NOT `0101110`, MOV `1000000` (FS=PASSA), LSL `0110000`, LSR `0110001`: RW=1.
  - LD `0100001`: RW=1, MD=01, FS=PASSA.
  - ST `0000001`: MW=1.
  - JMR `1100001`: BS=10.
  - BZ `0100000`: BS=01, PS=0.
  - BNZ `1100000`: BS=01, PS=1.
  - JMP `1000100`: BS=11.
  - JML `0000111`: BS=11, RW=1, MA=1, FS=PASSA.
  - Any undefined opcode decodes as NOP.
- **Register usage for hazard checks:**
  - SA is "used" unless MA=1, or the opcode is JMP or NOP.
  - SB is "used" only by the reg-reg ALU ops, SLT and ST.

## Timing
- DOF_EX outputs are registered: 1-cycle latency from `IF_DOF_*`.
- Reset value: every `DOF_EX_*` output is 0, `DOF_STALL`=0, all 32 registers are 0, FSM is in RUN.
- Reset asserted mid-stall: reset wins and the next state is RUN.
- **Hazard FSM** (RUN, STALL):
  - Hazard condition: `DOF_EX_RW=1`, `DOF_EX_DA≠0`, and `DOF_EX_DA` matches a used SA or SB.
  - RUN → STALL on a hazard. In that cycle:
    - `DOF_STALL`=1 (combinational).
    - DOF_EX loads a bubble (all control fields 0).
    - The IF inputs are not consumed.
  - STALL → RUN unconditionally. The producer is then in EX/WB, the bypass supplies its value, and the held instruction issues.
  - At most one stall cycle per instruction.
  - Back-to-back hazards on consecutive instructions give alternating issue/bubble.
- A write to register X and a read of X in the same cycle returns the new value (bypass).
- Producer–consumer distance ≥2 never stalls.

## Configuration
- `RISC_DOF_HAZARD_STALL_EN` defined: hazard FSM and `DOF_STALL` behave as specified above.
- Undefined:
  - FSM is removed and `DOF_STALL` is tied to 0.
  - No bubbles are inserted.
  - Software must separate dependent instructions with NOP.
  - The bypass remains in both builds.

## Structure
- Package `risc_pkg`:
  - opcode constants;
  - FS codes (PASSA, ADD, SUB, AND, OR, XOR, NOT, LSL, LSR);
  - the BS and MD encodings;
  - a packed control-word typedef {RW, MD, BS, PS, MW, FS, MA, MB, CS}.
- Sub-module `risc_dof_regfile`: 32×32, 2 read ports, 1 write port, synchronous reset clear, R0 hardwired to 0, write bypass.

## Test plan
- **Reset:** reset high for 2 cycles → all outputs 0; reading R1..R31 afterwards returns 0.
- **Immediate decode:** IR = ADI R1,R0,#0x0FF (R0=0) → next cycle RW=1, DA=1, BUS_A=0, BUS_B=0x000000FF. IR = ANI with IM=0x7FFF → BUS_B=0x00007FFF. SBI with IM=0x7FFF → BUS_B=0xFFFFFFFF.
- **Bypass:** `WB_RW=1`, `WB_DA=2`, `WB_BUS_D=0xAA` in the same cycle as IR = ADD R3,R2,R1 → `DOF_EX_BUS_A`=0xAA.
- **Branch:** BZ R0,#0xA with NPC=0xAC → BS=01, PS=0, BrA=0xB6. JML R22,#0xC with NPC=0xDA → BS=11, RW=1, BUS_A=0xDA, BrA=0xE6.
- **Hazard** (macro on): ADI R1 immediately followed by ADD R3,R2,R1 → `DOF_STALL`=1 for exactly 1 cycle; one bubble (all control 0); ADD then issues with the R1 value taken from the WB bypass. Macro off → no stall.
- **Edge cases:** an undefined opcode (e.g. `1111111`) → all control fields 0. A write to R0 of 0x1234 → R0 still reads 0. Reset during STALL → outputs 0 the next cycle.
